// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead FIFO with a ready/valid byte output.
// Define UART_RX_PARITY_EN for 8E1 frames (even parity bit checked before the stop bit).
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rx_in,
    output logic [7:0]                    char_out,
    output logic                          char_out_valid,
    input  logic                          char_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_err
);
    localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_e;

`ifdef UART_RX_PARITY_EN
    localparam state_e S_AFTER_DATA = S_PARITY;
`else
    localparam state_e S_AFTER_DATA = S_STOP;
`endif

    logic [1:0]    sync_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d, frame_err_q, frame_err_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic          rx_s, tick, tick_half, stop_sample, par_ok, byte_ok, pop, push_ok;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
`endif

    assign rx_s      = sync_q[1];
    assign tick      = (cnt_q == FULL_M1);
    assign tick_half = (cnt_q == HALF_M1);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_q      <= '1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            sync_q      <= {sync_q[0], rx_in};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    // Storage has no reset: clearing the pointers is enough to discard contents.
    always_ff @(posedge clk_in) begin
        if (push_ok) mem[wr_ptr_q] <= shift_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: if (tick_half) begin
                cnt_d   = '0;
                state_d = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (tick) begin
                cnt_d   = '0;
                shift_d = {rx_s, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = S_AFTER_DATA;
            end
            S_PARITY: if (tick) begin
                cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
                par_d   = rx_s;
`endif
                state_d = S_STOP;
            end
            S_STOP: if (tick) begin
                cnt_d   = '0;
                state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
`ifdef UART_RX_PARITY_EN
        par_ok = ~(^{shift_q, par_q});
`else
        par_ok = 1'b1;
`endif
        stop_sample = (state_q == S_STOP) && tick;
        byte_ok     = stop_sample && rx_s && par_ok;
        frame_err_d = stop_sample && !(rx_s && par_ok);
        pop         = (count_q != '0) && char_out_ready;
        // A full FIFO still accepts a byte when the head leaves in the same cycle.
        push_ok     = byte_ok && ((count_q != DEPTH_C) || pop);
        overflow_d  = byte_ok && (count_q == DEPTH_C) && !pop;
        wr_ptr_d    = wr_ptr_q + AW'(push_ok);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);
    end

    assign char_out       = mem[rd_ptr_q];
    assign char_out_valid = (count_q != '0);
    assign fifo_count     = count_q;
    assign overflow       = overflow_q;
    assign frame_err      = frame_err_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo: serial frames are driven bit by bit and every
// delivered byte is matched against a queue of the bytes the line carried.
module tb_uart_rx_fifo;
    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DIV    = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] char_out;
    logic       char_out_valid;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       frame_err;

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in(clk), .rst_in(rst), .rx_in(rx),
        .char_out(char_out), .char_out_valid(char_out_valid), .char_out_ready(ready),
        .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    byte unsigned q[$];
    int n_checks = 0, n_fail = 0;
    int ovf_seen = 0, fe_seen = 0, exp_ovf = 0, exp_fe = 0;
    bit rnd_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (overflow) ovf_seen++;
            if (frame_err) fe_seen++;
            if (char_out_valid && ready) begin
                if (q.size() == 0) check("pop_when_empty", 32'(char_out_valid), 32'd0);
                else check("rx_data", 32'(char_out), 32'(q.pop_front()));
            end
        end
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    // Model: a good frame joins the queue unless it already holds DEPTH bytes.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
        bit ok;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_flip);
`endif
        ok = stop && !par_flip;
        rx = stop;
        repeat (2) @(posedge clk);
        if (ok) begin
            if (q.size() < DEPTH) q.push_back(b);
            else exp_ovf++;
        end else begin
            exp_fe++;
        end
        repeat (DIV - 2) @(posedge clk);
        #1;
        if (!stop) begin
            repeat (30) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
        check({tag, "_drain"}, q.size(), 0);
        repeat (2) @(negedge clk);
        check({tag, "_count0"}, 32'(fifo_count), 32'd0);
        check({tag, "_valid0"}, 32'(char_out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        int base_ovf, base_fe;
        logic [7:0] b;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(char_out_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_fe", 32'(frame_err), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        ready = 1'b1;
        send_frame(8'h70, 1'b1, 1'b0);
        wait_drain("t1");

        ready = 1'b0;
        s = "position\n";
        for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1, 1'b0);
        @(negedge clk);
        check("t2_count9", 32'(fifo_count), 32'd9);
        @(posedge clk); #1 ready = 1'b1;
        wait_drain("t2");

        ready = 1'b0;
        base_ovf = ovf_seen;
        for (int i = 0; i < 17; i++) send_frame(8'($urandom), 1'b1, 1'b0);
        @(negedge clk);
        check("t3_count16", 32'(fifo_count), 32'd16);
        check("t3_ovf_pulses", ovf_seen - base_ovf, 1);
        @(posedge clk); #1 ready = 1'b1;
        wait_drain("t3");

        base_fe = fe_seen;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("t4_fe", fe_seen - base_fe, 0);
        check("t4_count", 32'(fifo_count), 32'd0);
        check("t4_valid", 32'(char_out_valid), 32'd0);
        @(posedge clk); #1;

        base_fe = fe_seen;
        send_frame(8'h41, 1'b0, 1'b0);
        @(negedge clk);
        check("t5_fe_pulses", fe_seen - base_fe, 1);
        check("t5_count", 32'(fifo_count), 32'd0);
        @(posedge clk); #1;
        send_frame(8'h42, 1'b1, 1'b0);
        wait_drain("t5");

        ready = 1'b0;
        for (int i = 0; i < 3; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0);
        @(negedge clk);
        check("t6_count3", 32'(fifo_count), 32'd3);
        @(posedge clk); #1;
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        rst = 1'b1;
        q.delete();
        rx = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_valid", 32'(char_out_valid), 32'd0);
        check("t6_rst_count", 32'(fifo_count), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_frame(8'h55, 1'b1, 1'b0);
        wait_drain("t6");

`ifdef UART_RX_PARITY_EN
        base_fe = fe_seen;
        send_frame(8'h03, 1'b1, 1'b1);
        @(negedge clk);
        check("par_bad_fe", fe_seen - base_fe, 1);
        check("par_bad_count", 32'(fifo_count), 32'd0);
        @(posedge clk); #1;
        send_frame(8'h03, 1'b1, 1'b0);
        wait_drain("par_good");
`endif

        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    b = 8'($urandom);
                    send_frame(b, ($urandom_range(0, 7) != 0), 1'b0);
                    repeat ($urandom_range(0, 20)) @(posedge clk);
                    #1;
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 ready = 1'($urandom_range(0, 1));
                end
            end
        join
        ready = 1'b1;
        wait_drain("rnd");

        check("total_ovf", ovf_seen, exp_ovf);
        check("total_fe", fe_seen, exp_fe);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
